// File: rtl/xcvr_seq_pkg.sv
// Shared definitions for the xcvr_seq bus-cycle sequencer: state encoding,
// direction constants and timer width.
package xcvr_seq_pkg;

    localparam int CNT_W = 4;

    localparam logic DIR_A_TO_B = 1'b1;
    localparam logic DIR_B_TO_A = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_TURN   = 2'd3
    } state_t;

    // A phase of N cycles runs the down-counter from N-1 to terminal count.
    function automatic logic [CNT_W-1:0] cnt_preset(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/xcvr_seq_timer.sv
// Loadable 4-bit down-counter with async clear, sync load, count enable and
// terminal-count flag; holds at zero instead of wrapping.
module xcvr_seq_timer
    import xcvr_seq_pkg::*;
(
    input  logic             clock,
    input  logic             res,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/xcvr_seq.sv
// Control sequencer for a 245-style bidirectional transceiver: turns a single
// core request into a setup / enable / turnaround bus cycle with registered outputs.
module xcvr_seq
    import xcvr_seq_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic       clock,
    input  logic       res,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] wdata,
    input  logic [7:0] a_in,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       busy,
    output logic       dir,
    output logic       n_oe,
    output logic [7:0] a_drv,
    output logic       a_oe_n,
    output logic [1:0] state_dbg
);

    state_t state;
    state_t state_nxt;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_tc;

    logic [7:0] rdata_nxt;
    logic       ack_nxt;
    logic       busy_nxt;
    logic       dir_nxt;
    logic       n_oe_nxt;
    logic [7:0] a_drv_nxt;
    logic       a_oe_n_nxt;

    // One timer serves both the enable window and the turnaround gap.
    xcvr_seq_timer u_timer (
        .clock    (clock),
        .res      (res),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .count    (tmr_count),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (req) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (tmr_tc) state_nxt = ST_TURN;
            ST_TURN:   if (tmr_tc) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tmr_load     = (state == ST_SETUP) || ((state == ST_ACTIVE) && tmr_tc);
        tmr_load_val = (state == ST_SETUP) ? cnt_preset(WAIT_CYCLES)
                                           : cnt_preset(TURN_CYCLES);
        tmr_en       = (state == ST_ACTIVE) || (state == ST_TURN);
    end

    // Next values of the output registers; ack is a pulse so it defaults low.
    always_comb begin
        rdata_nxt  = rdata;
        ack_nxt    = 1'b0;
        busy_nxt   = busy;
        dir_nxt    = dir;
        n_oe_nxt   = n_oe;
        a_drv_nxt  = a_drv;
        a_oe_n_nxt = a_oe_n;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    dir_nxt    = we ? DIR_A_TO_B : DIR_B_TO_A;
                    a_drv_nxt  = wdata;
                    a_oe_n_nxt = ~we;
                    busy_nxt   = 1'b1;
                end
            end
            ST_SETUP: begin
                n_oe_nxt = 1'b0;
            end
            ST_ACTIVE: begin
                if (tmr_tc) begin
                    n_oe_nxt = 1'b1;
                    ack_nxt  = 1'b1;
                    if (dir == DIR_B_TO_A) rdata_nxt = a_in;
                end
            end
            ST_TURN: begin
                // The A driver stays on through turnaround to hold write data.
                if (tmr_tc) begin
                    a_oe_n_nxt = 1'b1;
                    busy_nxt   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            rdata  <= '0;
            ack    <= 1'b0;
            busy   <= 1'b0;
            dir    <= DIR_B_TO_A;
            n_oe   <= 1'b1;
            a_drv  <= '0;
            a_oe_n <= 1'b1;
        end else begin
            rdata  <= rdata_nxt;
            ack    <= ack_nxt;
            busy   <= busy_nxt;
            dir    <= dir_nxt;
            n_oe   <= n_oe_nxt;
            a_drv  <= a_drv_nxt;
            a_oe_n <= a_oe_n_nxt;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_xcvr_seq.sv
// Bench for xcvr_seq: default-parameter instance with an ack scoreboard and
// invariant monitor, plus a WAIT=1/TURN=3 instance checked against a timing table.
module tb_xcvr_seq;

    localparam int W_A = 2;
    localparam int T_A = 1;
    localparam int W_B = 1;
    localparam int T_B = 3;

    logic clk;
    logic res;

    logic       req_a, we_a;
    logic [7:0] wdata_a, a_in_a;
    logic [7:0] rdata_a, a_drv_a;
    logic       ack_a, busy_a, dir_a, n_oe_a, a_oe_n_a;
    logic [1:0] state_a;

    logic       req_b, we_b;
    logic [7:0] wdata_b, a_in_b;
    logic [7:0] rdata_b, a_drv_b;
    logic       ack_b, busy_b, dir_b, n_oe_b, a_oe_n_b;
    logic [1:0] state_b;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    logic [7:0] exp_q[$];
    int         exp_edge_q[$];
    logic [7:0] model_rdata = 8'h00;
    int         ack_cnt = 0;

    int   viol_dir = 0;
    int   viol_aoe = 0;
    int   viol_noe = 0;
    int   hi_run = 0;
    int   last_gap = 0;
    logic seen_low = 1'b0;
    logic prev_dir = 1'b0;
    logic prev_noe = 1'b1;

    xcvr_seq #(.WAIT_CYCLES(W_A), .TURN_CYCLES(T_A)) dut_a (
        .clock(clk), .res(res), .req(req_a), .we(we_a), .wdata(wdata_a), .a_in(a_in_a),
        .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .dir(dir_a), .n_oe(n_oe_a),
        .a_drv(a_drv_a), .a_oe_n(a_oe_n_a), .state_dbg(state_a)
    );

    xcvr_seq #(.WAIT_CYCLES(W_B), .TURN_CYCLES(T_B)) dut_b (
        .clock(clk), .res(res), .req(req_b), .we(we_b), .wdata(wdata_b), .a_in(a_in_b),
        .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .dir(dir_b), .n_oe(n_oe_b),
        .a_drv(a_drv_b), .a_oe_n(a_oe_n_b), .state_dbg(state_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Driver: present one request on instance A and log the expected completion.
    task automatic issue_a(input logic w, input logic [7:0] d, input logic [7:0] ain, output int k);
        req_a   = 1'b1;
        we_a    = w;
        wdata_a = d;
        a_in_a  = ain;
        k = edge_cnt + 1;
        if (!w) model_rdata = ain;
        exp_edge_q.push_back(k + 1 + W_A);
        exp_q.push_back(model_rdata);
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (busy_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("idle_timeout", {31'd0, busy_a}, 32'd0);
    endtask

    // Scoreboard and invariant monitor for instance A
    always @(negedge clk) begin
        if (res) begin
            prev_dir = dir_a;
            prev_noe = n_oe_a;
            hi_run   = 0;
            seen_low = 1'b0;
        end else begin
            if (ack_a) begin
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    check_val("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    check_val("ack_edge", edge_cnt, exp_edge_q.pop_front());
                    check_val("ack_rdata", {24'd0, rdata_a}, {24'd0, exp_q.pop_front()});
                end
            end
            if ((dir_a !== prev_dir) && !(n_oe_a && prev_noe)) viol_dir++;
            if (!a_oe_n_a && !dir_a) viol_aoe++;
            if (!n_oe_a && state_a != 2'd2) viol_noe++;
            if (n_oe_a) begin
                hi_run++;
            end else begin
                if (seen_low && hi_run > 0) last_gap = hi_run;
                hi_run   = 0;
                seen_low = 1'b1;
            end
            prev_dir = dir_a;
            prev_noe = n_oe_a;
        end
    end

    initial begin
        int k;
        int kb;
        int low_cnt;
        res = 1'b1;
        req_a = 0; we_a = 0; wdata_a = 0; a_in_a = 0;
        req_b = 0; we_b = 0; wdata_b = 0; a_in_b = 0;
        repeat (3) @(negedge clk);

        check_val("rst_dir", {31'd0, dir_a}, 32'd0);
        check_val("rst_n_oe", {31'd0, n_oe_a}, 32'd1);
        check_val("rst_a_oe_n", {31'd0, a_oe_n_a}, 32'd1);
        check_val("rst_a_drv", {24'd0, a_drv_a}, 32'd0);
        check_val("rst_rdata", {24'd0, rdata_a}, 32'd0);
        check_val("rst_ack", {31'd0, ack_a}, 32'd0);
        check_val("rst_busy", {31'd0, busy_a}, 32'd0);
        check_val("rst_state", {30'd0, state_a}, 32'd0);
        res = 1'b0;
        repeat (2) @(negedge clk);

        // Write 0xc6
        issue_a(1'b1, 8'hc6, 8'h00, k);
        @(negedge clk);
        req_a = 1'b0;
        check_val("wr_dir_e0", {31'd0, dir_a}, 32'd1);
        check_val("wr_aoe_e0", {31'd0, a_oe_n_a}, 32'd0);
        check_val("wr_adrv_e0", {24'd0, a_drv_a}, 32'hc6);
        check_val("wr_noe_e0", {31'd0, n_oe_a}, 32'd1);
        check_val("wr_busy_e0", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        check_val("wr_noe_e1", {31'd0, n_oe_a}, 32'd0);
        @(negedge clk);
        check_val("wr_noe_e2", {31'd0, n_oe_a}, 32'd0);
        @(negedge clk);
        check_val("wr_noe_e3", {31'd0, n_oe_a}, 32'd1);
        check_val("wr_aoe_e3", {31'd0, a_oe_n_a}, 32'd0);
        check_val("wr_busy_e3", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        check_val("wr_busy_e4", {31'd0, busy_a}, 32'd0);
        check_val("wr_aoe_e4", {31'd0, a_oe_n_a}, 32'd1);
        check_val("wr_state_e4", {30'd0, state_a}, 32'd0);

        // Read 0x35
        @(negedge clk);
        issue_a(1'b0, 8'h00, 8'h35, k);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 0) req_a = 1'b0;
            check_val("rd_dir_aoe", {30'd0, dir_a, a_oe_n_a}, 32'b01);
        end
        a_in_a = 8'hca;
        repeat (3) @(negedge clk);
        check_val("rd_hold", {24'd0, rdata_a}, 32'h35);

        // Back-to-back: write 0x7f then read 0x5a with req held high
        issue_a(1'b1, 8'h7f, 8'hca, k);
        @(negedge clk);
        we_a   = 1'b0;
        a_in_a = 8'h5a;
        model_rdata = 8'h5a;
        exp_edge_q.push_back(k + 5 + 1 + W_A);
        exp_q.push_back(model_rdata);
        repeat (5) @(negedge clk);
        req_a = 1'b0;
        check_val("b2b_accept", {30'd0, state_a}, 32'd1);
        wait_idle_a();
        check_val("b2b_gap", last_gap, T_A + 2);

        // req pulse during ACTIVE must be ignored
        @(negedge clk);
        issue_a(1'b1, 8'h11, 8'h5a, k);
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        check_val("pulse_state", {30'd0, state_a}, 32'd2);
        check_val("pulse_busy", {31'd0, busy_a}, 32'd1);
        wait_idle_a();
        repeat (4) @(negedge clk);
        check_val("pulse_idle", {30'd0, state_a}, 32'd0);

        // Reset during ACTIVE of a read aborts the cycle
        issue_a(1'b0, 8'h00, 8'h99, k);
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        res = 1'b1;
        #1;
        void'(exp_q.pop_back());
        void'(exp_edge_q.pop_back());
        model_rdata = 8'h00;
        check_val("abort_n_oe", {31'd0, n_oe_a}, 32'd1);
        check_val("abort_a_oe_n", {31'd0, a_oe_n_a}, 32'd1);
        check_val("abort_busy", {31'd0, busy_a}, 32'd0);
        check_val("abort_rdata", {24'd0, rdata_a}, 32'd0);
        check_val("abort_ack", {31'd0, ack_a}, 32'd0);
        repeat (2) @(negedge clk);
        res = 1'b0;
        repeat (6) @(negedge clk);
        check_val("abort_rdata_after", {24'd0, rdata_a}, 32'd0);

        // WAIT=1, TURN=3 instance: read 0x3c against a per-edge timing table
        req_b  = 1'b1;
        we_b   = 1'b0;
        a_in_b = 8'h3c;
        kb = edge_cnt + 1;
        low_cnt = 0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (j == 0) req_b = 1'b0;
            check_val("b_edge", edge_cnt, kb + j);
            check_val("b_n_oe", {31'd0, n_oe_b}, (j == 1) ? 32'd0 : 32'd1);
            check_val("b_ack", {31'd0, ack_b}, (j == 2) ? 32'd1 : 32'd0);
            check_val("b_busy", {31'd0, busy_b}, (j <= 4) ? 32'd1 : 32'd0);
            if (j == 2) check_val("b_rdata", {24'd0, rdata_b}, 32'h3c);
            if (!n_oe_b) low_cnt++;
        end
        check_val("b_low_cnt", low_cnt, 32'd1);

        // Final report
        check_val("sb_empty", exp_q.size(), 32'd0);
        check_val("ack_total", ack_cnt, 32'd5);
        check_val("inv_dir_change", viol_dir, 32'd0);
        check_val("inv_aoe_dir", viol_aoe, 32'd0);
        check_val("inv_noe_active", viol_noe, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
